// File: rtl/md_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// md_scheduler_pkg
//   Shared definitions for the multiply/divide scheduler:
//     - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO,
//       MD_MADD, MD_MADDU and, when enabled, MD_MSUB, MD_MSUBU)
//     - scheduler state encoding
//     - op classification helpers
//   Configuration macro: MD_MADD_EN
//     defined   : multiply-accumulate ops are live. Ten op codes do not fit in
//                 three bits, so the op field grows to four bits.
//     undefined : three-bit op field. Codes MD_MADD/MD_MADDU decode as no-ops.
// ---------------------------------------------------------------------------
package md_scheduler_pkg;

`ifdef MD_MADD_EN
    localparam int MD_OP_W = 4;
`else
    localparam int MD_OP_W = 3;
`endif

    typedef logic [MD_OP_W-1:0] md_op_t;

    localparam md_op_t MD_MULT  = md_op_t'(0);
    localparam md_op_t MD_MULTU = md_op_t'(1);
    localparam md_op_t MD_DIV   = md_op_t'(2);
    localparam md_op_t MD_DIVU  = md_op_t'(3);
    localparam md_op_t MD_MTHI  = md_op_t'(4);
    localparam md_op_t MD_MTLO  = md_op_t'(5);
    localparam md_op_t MD_MADD  = md_op_t'(6);
    localparam md_op_t MD_MADDU = md_op_t'(7);
`ifdef MD_MADD_EN
    localparam md_op_t MD_MSUB  = md_op_t'(8);
    localparam md_op_t MD_MSUBU = md_op_t'(9);
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // Ops that occupy the unit for several cycles and raise busy.
    function automatic logic is_long_op(input md_op_t op);
        logic r;
        r = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_scheduler_core.sv
// ---------------------------------------------------------------------------
// md_core
//   Purely combinational datapath of the multiply/divide unit. Produces the
//   64-bit {hi,lo} result for the latched op and operands.
//   Ports:
//     op      in   latched md op
//     a       in   32  latched operand A (rs)
//     b       in   32  latched operand B (rt)
//     hi, lo  in   32  current HI/LO (accumulate base, and pass-through)
//     result  out  64  {hi,lo} to commit
//     wr_en   out  1   result should be written (low for divide by zero)
//   Configuration macro: MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
// ---------------------------------------------------------------------------
import md_scheduler_pkg::*;

module md_core (
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        wr_en
);

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    // Low 64 bits of the product of sign-extended operands equal the signed
    // 64-bit product, so one multiplier form serves both flavours.
    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'b0, a} * {32'b0, b};

    // Signed division is done on magnitudes and the signs restored, which
    // gives truncation toward zero with the remainder following the dividend.
    // 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign is_signed = (op == MD_DIV);
    assign a_neg     = is_signed & a[31];
    assign b_neg     = is_signed & b[31];
    assign mag_a     = a_neg ? (32'd0 - a) : a;
    assign mag_b     = b_neg ? (32'd0 - b) : b;
    // Keep the divider away from a zero divisor; the result is discarded then.
    assign div_b     = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag     = mag_a / div_b;
    assign r_mag     = mag_a % div_b;
    assign quot      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem       = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        result = {hi, lo};
        wr_en  = 1'b0;
        case (op)
            MD_MULT: begin
                result = prod_s;
                wr_en  = 1'b1;
            end
            MD_MULTU: begin
                result = prod_u;
                wr_en  = 1'b1;
            end
            MD_DIV, MD_DIVU: begin
                result = {rem, quot};
                wr_en  = (b != 32'd0);
            end
`ifdef MD_MADD_EN
            MD_MADD: begin
                result = {hi, lo} + prod_s;
                wr_en  = 1'b1;
            end
            MD_MADDU: begin
                result = {hi, lo} + prod_u;
                wr_en  = 1'b1;
            end
            MD_MSUB: begin
                result = {hi, lo} - prod_s;
                wr_en  = 1'b1;
            end
            MD_MSUBU: begin
                result = {hi, lo} - prod_u;
                wr_en  = 1'b1;
            end
`endif
            default: begin
                result = {hi, lo};
                wr_en  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_scheduler.sv
// ---------------------------------------------------------------------------
// md_scheduler
//   Sequences the multi-cycle multiply/divide unit and its HI/LO registers for
//   the 5-stage MIPS pipeline. Accepts md ops from E, holds busy for a fixed
//   latency, commits HI/LO and raises the D-stage stall.
//   Parameters:
//     MULT_CYC  busy cycles for mult/multu (and accumulate ops), 1..16
//     DIV_CYC   busy cycles for div/divu, MULT_CYC..16
//   Ports:
//     clk       in   1   system clock, rising edge
//     reset_n   in   1   synchronous reset, active low
//     start     in   1   E-stage instr is an md op this cycle
//     md_op     in   W   op code (md_scheduler_pkg)
//     rs_val    in   32  operand A (forwarded)
//     rt_val    in   32  operand B (forwarded)
//     d_is_md   in   1   D-stage instr is md op or mfhi/mflo
//     busy      out  1   mult/div in flight
//     stall     out  1   freeze F/D, bubble E (combinational)
//     done      out  1   one-cycle pulse after a mult/div commit
//     hi, lo    out  32  HI/LO registers
//   Configuration macro: MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
// ---------------------------------------------------------------------------
import md_scheduler_pkg::*;

module md_scheduler #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  md_op_t      md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Counter is loaded with latency-1 so that busy lasts exactly CYC cycles.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC - 1);

    md_state_t   state_reg, state_next;
    logic [3:0]  cnt_reg,   cnt_next;
    md_op_t      op_reg,    op_next;
    logic [31:0] a_reg,     a_next;
    logic [31:0] b_reg,     b_next;
    logic [31:0] hi_reg,    hi_next;
    logic [31:0] lo_reg,    lo_next;
    logic        done_reg,  done_next;

    logic [63:0] core_result;
    logic        core_wr_en;

    md_core u_core (
        .op     (op_reg),
        .a      (a_reg),
        .b      (b_reg),
        .hi     (hi_reg),
        .lo     (lo_reg),
        .result (core_result),
        .wr_en  (core_wr_en)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            op_reg    <= MD_MULT;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (is_long_op(md_op)) begin
                        op_next    = md_op;
                        a_next     = rs_val;
                        b_next     = rt_val;
                        cnt_next   = is_div_op(md_op) ? DIV_LOAD : MULT_LOAD;
                        state_next = ST_RUN;
                    end else if (md_op == MD_MTHI) begin
                        hi_next = rs_val;
                    end else if (md_op == MD_MTLO) begin
                        lo_next = rs_val;
                    end
                end
            end
            ST_RUN: begin
                // A start here is a hazard-unit violation and is dropped.
                if (cnt_reg == 4'd0) begin
                    if (core_wr_en) begin
                        hi_next = core_result[63:32];
                        lo_next = core_result[31:0];
                    end
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy  = (state_reg == ST_RUN);
    // Stall covers the issue cycle too, so a dependent D-stage op never sees
    // stale HI/LO; it drops in the cycle the commit becomes visible.
    assign stall = d_is_md & (busy | (start & is_long_op(md_op)));
    assign done  = done_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule
